reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Parametrised successor to the 4x16 datapath register file: 2**ADDR_W registers of WIDTH bits, two combinational read ports and one synchronous ALU write port.
- Adds a second write path, the "fill" port, for multi-cycle data-memory loads.
- A per-register pending scoreboard tells the control unit when a source or destination register is still waiting on a load.
- Sits between the decode/control logic and the ALU/memory stage of the multi-cycle CPU.

Parameters:
- WIDTH, 16, register data width in bits (>=2).
- ADDR_W, 2, register address width; NREGS = 2**ADDR_W (>=2).

Ports:
- clock  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous, active-low reset.
- rr1  input  ADDR_W  read address, port 1.
- rr2  input  ADDR_W  read address, port 2.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.
- rd1_busy  output  1  register rr1 is pending.
- rd2_busy  output  1  register rr2 is pending.
- regwrite  input  1  ALU write strobe.
- wr  input  ADDR_W  ALU write address.
- wd  input  WIDTH  ALU write data.
- issue_valid  input  1  load issued; mark issue_reg pending.
- issue_reg  input  ADDR_W  load destination register.
- issue_ready  output  1  an issue this cycle is accepted.
- fill_valid  input  1  load data returning.
- fill_reg  input  ADDR_W  load destination register being filled.
- fill_data  input  WIDTH  load data.
- busy_mask  output  NREGS  pending bit per register.
- pending_cnt  output  ADDR_W+1  number of pending registers.
- waw_err  output  1  sticky hazard flag.

Behaviour:
Reset:
- reset_n low asynchronously clears all registers, busy_mask, pending_cnt and waw_err to 0.
- Reset mid-load discards the pending state. A fill arriving after reset is still written normally, with no error.

Register 0:
- Reads always return 0.
- Writes and fills to register 0 are ignored.
- Register 0 is never busy. An issue to register 0 is accepted and has no effect.

Writes:
- Registers update on the rising clock edge only.
- If regwrite and fill_valid hit the same register in the same cycle, regwrite data wins (the ALU result is younger). The busy bit is still cleared by the fill.

Scoreboard:
- issue_ready = !busy_mask[issue_reg] || (fill_valid && fill_reg==issue_reg).
- An accepted issue (issue_valid && issue_ready) sets busy[issue_reg] at the edge.
- fill_valid clears busy[fill_reg].
- Issue and fill to the same register in the same cycle leaves busy set, for the new load.
- An issue to a busy register with no coincident fill is refused. No state changes and waw_err is not set.

Counter:
- pending_cnt equals the popcount of busy_mask after every edge.
- It is maintained incrementally (+1, -1, or 0 when both happen) and never wraps: its maximum is NREGS-1.

Hazard flag:
- waw_err sets and holds until reset on either of these:
  - regwrite to a busy register other than 0, with no same-cycle fill to that register;
  - fill_valid to a non-busy register other than 0.
- The write itself still occurs.

Read busy outputs:
- rd1_busy and rd2_busy are combinational: busy_mask[rr1] and busy_mask[rr2]. They are 0 for register 0.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined:
  - rdN returns the same-cycle write value when it targets rrN (rrN != 0). regwrite has priority over fill.
  - rdN_busy is forced to 0 when a same-cycle fill targets rrN.
- Undefined: reads return pre-edge register contents only, and busy reflects busy_mask only.

Test Plan:
- Reset, then regwrite wr=1, wd=16'h0005; next cycle rr1=1 -> rd1=16'h0005, rd2 with rr2=0 -> 16'h0000. Writing 16'hFFFF to register 0 -> still reads 0.
- issue_valid, issue_reg=2 -> busy_mask=4'b0100, pending_cnt=1, rd1_busy=1 for rr1=2. Second issue to register 2 -> issue_ready=0, pending_cnt stays 1. fill_reg=2, fill_data=16'h0007 -> register 2 reads 16'h0007, busy_mask=0, pending_cnt=0.
- Same cycle: fill_reg=3 with data 16'h1111 and regwrite wr=3 with wd=16'h2222 -> register 3 reads 16'h2222, busy[3]=0, waw_err=0.
- Register 1 busy; same cycle fill_reg=1 and issue_reg=1 -> issue_ready=1, busy[1] stays 1, pending_cnt stays 1.
- regwrite to busy register 3 -> waw_err=1, holds across later cycles. Assert reset_n mid-cycle -> waw_err, busy_mask and pending_cnt drop to 0 immediately, without waiting for a clock edge.
- With REG_FILE_SB_BYPASS_EN: regwrite wr=2, wd=16'h00AB, rr1=2 in the same cycle -> rd1=16'h00AB before the edge. Without the macro -> rd1 shows the old value until after the edge.

Source files
------------

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with a load-fill port and a per-register pending scoreboard
// Optional same-cycle read bypass: define REG_FILE_SB_BYPASS_EN.
module reg_file_sb #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   rr1,
  input  logic [ADDR_W-1:0]   rr2,
  output logic [WIDTH-1:0]    rd1,
  output logic [WIDTH-1:0]    rd2,
  output logic                rd1_busy,
  output logic                rd2_busy,
  input  logic                regwrite,
  input  logic [ADDR_W-1:0]   wr,
  input  logic [WIDTH-1:0]    wd,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_reg,
  output logic                issue_ready,
  input  logic                fill_valid,
  input  logic [ADDR_W-1:0]   fill_reg,
  input  logic [WIDTH-1:0]    fill_data,
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic [ADDR_W:0]     pending_cnt,
  output logic                waw_err
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [WIDTH-1:0]  regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [NREGS-1:0]  orphan_q, orphan_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              waw_q, waw_d;

  logic wr_nz, fill_nz, issue_acc, cnt_inc, cnt_dec;

  assign wr_nz       = regwrite && (wr != '0);
  assign fill_nz     = fill_valid && (fill_reg != '0);
  assign issue_ready = !busy_q[issue_reg] || (fill_valid && (fill_reg == issue_reg));
  assign issue_acc   = issue_valid && issue_ready && (issue_reg != '0);

  // Fill lands first so a same-cycle ALU write to the same register overrides it.
  always_comb begin
    regs_d = regs_q;
    if (fill_nz) regs_d[fill_reg] = fill_data;
    if (wr_nz)   regs_d[wr]       = wd;
  end

  always_comb begin
    busy_d = busy_q;
    if (fill_valid) busy_d[fill_reg] = 1'b0;
    if (issue_acc)  busy_d[issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // A fill to the register being re-issued the same cycle keeps it pending: net zero.
  assign cnt_inc = issue_acc && !busy_q[issue_reg];
  assign cnt_dec = fill_nz && busy_q[fill_reg] && !(issue_acc && (issue_reg == fill_reg));

  always_comb begin
    cnt_d = cnt_q;
    case ({cnt_inc, cnt_dec})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Orphan bits mark registers whose load may have been dropped by reset; a late
  // fill to such a register is legitimate and must not raise the hazard flag.
  always_comb begin
    orphan_d = orphan_q;
    if (fill_nz)   orphan_d[fill_reg]  = 1'b0;
    if (issue_acc) orphan_d[issue_reg] = 1'b0;
  end

  always_comb begin
    waw_d = waw_q;
    if (wr_nz && busy_q[wr] && !(fill_valid && (fill_reg == wr))) waw_d = 1'b1;
    if (fill_nz && !busy_q[fill_reg] && !orphan_q[fill_reg])       waw_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q   <= '0;
      orphan_q <= '1;
      cnt_q    <= '0;
      waw_q    <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      orphan_q <= orphan_d;
      cnt_q    <= cnt_d;
      waw_q    <= waw_d;
    end
  end

  always_comb begin
    rd1      = regs_q[rr1];
    rd2      = regs_q[rr2];
    rd1_busy = busy_q[rr1];
    rd2_busy = busy_q[rr2];
`ifdef REG_FILE_SB_BYPASS_EN
    if (fill_valid && (fill_reg == rr1)) begin
      rd1      = fill_data;
      rd1_busy = 1'b0;
    end
    if (fill_valid && (fill_reg == rr2)) begin
      rd2      = fill_data;
      rd2_busy = 1'b0;
    end
    if (regwrite && (wr == rr1)) rd1 = wd;
    if (regwrite && (wr == rr2)) rd2 = wd;
`endif
    if (rr1 == '0) begin
      rd1      = '0;
      rd1_busy = 1'b0;
    end
    if (rr2 == '0) begin
      rd2      = '0;
      rd2_busy = 1'b0;
    end
  end

  assign busy_mask   = busy_q;
  assign pending_cnt = cnt_q;
  assign waw_err     = waw_q;

endmodule
